// File: rtl/two_way_karatsuba_seq_pkg.sv
// Shared definitions for the two-way Karatsuba multiplier: FSM state
// encoding, operation-mode constants and the cycle-count helper.
package karatsuba_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_INT   = 1'b0;
  localparam logic MODE_CLMUL = 1'b1;

  // Rounded-up integer division, used to size the MUL phase.
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/two_way_karatsuba_seq_serial_mul_unit.sv
// Serial shift-add (or shift-XOR for carry-less) multiplier unit.
// Operands are captured on clear; each enabled cycle consumes BPC
// multiplier bits from the LSB end. Bits beyond OPW shift in as zero,
// so extra iterations in the last cycle contribute nothing.
module serial_mul_unit
  import karatsuba_pkg::*;
#(
  parameter int OPW = 129,
  parameter int BPC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic               mode,
  input  logic [OPW-1:0]     multiplicand,
  input  logic [OPW-1:0]     multiplier,
  output logic [2*OPW-1:0]   acc
);

  logic [2*OPW-1:0] mcand_q, mcand_d;
  logic [2*OPW-1:0] acc_q, acc_d;
  logic [OPW-1:0]   mplier_q, mplier_d;

  // Next-state: load operands on clear, otherwise accumulate BPC partial products.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (clear) begin
      mcand_d  = {{OPW{1'b0}}, multiplicand};
      mplier_d = multiplier;
      acc_d    = '0;
    end else if (en) begin
      for (int j = 0; j < BPC; j++) begin
        if (mplier_q[j]) begin
          if (mode == MODE_CLMUL) begin
            acc_d = acc_d ^ (mcand_q << j);
          end else begin
            acc_d = acc_d + (mcand_q << j);
          end
        end else begin
          acc_d = acc_d;
        end
      end
      mcand_d  = mcand_q << BPC;
      mplier_d = mplier_q >> BPC;
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/two_way_karatsuba_seq.sv
// Two-way Karatsuba multiplier, integer or carry-less per operation.
// Three serial sub-units compute hi*hi, lo*lo and (hi op lo)*(hi op lo)
// in parallel; a single COMB cycle merges them into the 2*WIDTH product.
// Optional: define KARATSUBA_OP_COUNT_EN to add the op_count output.
module two_way_karatsuba_seq
  import karatsuba_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
`ifdef KARATSUBA_OP_COUNT_EN
  ,
  output logic [31:0]          op_count
`endif
);

  localparam int H   = WIDTH / 2;
  localparam int OPW = H + 1;
  localparam int NS  = ceil_div(OPW, BPC);
  localparam int CW  = $clog2(NS * BPC + 1) + 1;
  localparam logic [CW-1:0] BPC_C = CW'(BPC);
  localparam logic [CW-1:0] OPW_C = CW'(OPW);

  state_e             state_q;
  logic               busy_q, done_q, mode_q;
  logic [2*WIDTH-1:0] c_q, c_d;
  logic [CW-1:0]      bitcnt_q;

  logic               accept_s, mul_en_s;
  logic [OPW-1:0]     sa_s, sc_s;
  logic [2*OPW-1:0]   p0_s, p2_s, pm_s, mid_s;
  logic [2*WIDTH-1:0] p0_x, p2_x, mid_x;

  assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));
  assign mul_en_s = (state_q == MUL);

  // Pre-add (integer) or pre-XOR (carry-less) of the operand halves.
  always_comb begin
    if (mode == MODE_INT) begin
      sa_s = {1'b0, a[WIDTH-1:H]} + {1'b0, a[H-1:0]};
      sc_s = {1'b0, b[WIDTH-1:H]} + {1'b0, b[H-1:0]};
    end else begin
      sa_s = {1'b0, a[WIDTH-1:H] ^ a[H-1:0]};
      sc_s = {1'b0, b[WIDTH-1:H] ^ b[H-1:0]};
    end
  end

  serial_mul_unit #(.OPW(OPW), .BPC(BPC)) u_p0 (
    .clk(clk), .rst(rst), .clear(accept_s), .en(mul_en_s), .mode(mode_q),
    .multiplicand({1'b0, a[WIDTH-1:H]}), .multiplier({1'b0, b[WIDTH-1:H]}),
    .acc(p0_s)
  );

  serial_mul_unit #(.OPW(OPW), .BPC(BPC)) u_p2 (
    .clk(clk), .rst(rst), .clear(accept_s), .en(mul_en_s), .mode(mode_q),
    .multiplicand({1'b0, a[H-1:0]}), .multiplier({1'b0, b[H-1:0]}),
    .acc(p2_s)
  );

  serial_mul_unit #(.OPW(OPW), .BPC(BPC)) u_pm (
    .clk(clk), .rst(rst), .clear(accept_s), .en(mul_en_s), .mode(mode_q),
    .multiplicand(sa_s), .multiplier(sc_s),
    .acc(pm_s)
  );

  // Combine stage: recover the middle term and assemble the full product.
  always_comb begin
    if (mode_q == MODE_CLMUL) begin
      mid_s = pm_s ^ p0_s ^ p2_s;
    end else begin
      mid_s = pm_s - p0_s - p2_s;
    end
    p0_x  = {{(2*WIDTH-2*OPW){1'b0}}, p0_s};
    p2_x  = {{(2*WIDTH-2*OPW){1'b0}}, p2_s};
    mid_x = {{(2*WIDTH-2*OPW){1'b0}}, mid_s};
    if (mode_q == MODE_CLMUL) begin
      c_d = (p0_x << WIDTH) ^ (mid_x << H) ^ p2_x;
    end else begin
      c_d = (p0_x << WIDTH) + (mid_x << H) + p2_x;
    end
  end

  // Control FSM with registered busy/done/product outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_q      <= '0;
      mode_q   <= MODE_INT;
      bitcnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q   <= mode;
            bitcnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= MUL;
          end else begin
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        MUL: begin
          bitcnt_q <= bitcnt_q + BPC_C;
          if ((bitcnt_q + BPC_C) >= OPW_C) begin
            state_q <= COMB;
          end else begin
            state_q <= MUL;
          end
        end
        COMB: begin
          c_q     <= c_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

`ifdef KARATSUBA_OP_COUNT_EN
  logic [31:0] op_count_q;

  // Completed-operation counter; advances as each done pulse is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 32'd0;
    end else if (state_q == COMB) begin
      op_count_q <= op_count_q + 32'd1;
    end else begin
      op_count_q <= op_count_q;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_two_way_karatsuba_seq.sv
// Self-checking bench for two_way_karatsuba_seq: a WIDTH=8/BPC=1 and a
// WIDTH=256/BPC=4 instance, each tracked by a cycle-level behavioural
// model (product by plain arithmetic, timing by a busy-cycle countdown).
module tb_two_way_karatsuba_seq;

  localparam int LAT8 = 7;   // NS = ceil(5/1)   = 5, +2
  localparam int LAT2 = 35;  // NS = ceil(129/4) = 33, +2

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         st8, md8, busy8, done8;
  logic [7:0]   a8, b8;
  logic [15:0]  c8;
  logic         st2, md2, busy2, done2;
  logic [255:0] a2, b2;
  logic [511:0] c2;
`ifdef KARATSUBA_OP_COUNT_EN
  logic [31:0]  opc8, opc2;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  two_way_karatsuba_seq #(.WIDTH(8), .BPC(1)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .mode(md8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .c(c8)
`ifdef KARATSUBA_OP_COUNT_EN
    , .op_count(opc8)
`endif
  );

  two_way_karatsuba_seq #(.WIDTH(256), .BPC(4)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .mode(md2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .c(c2)
`ifdef KARATSUBA_OP_COUNT_EN
    , .op_count(opc2)
`endif
  );

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference product: plain integer multiply, or GF(2)[x] multiply.
  function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y, input logic m);
    logic [511:0] r;
    r = '0;
    if (m) begin
      for (int i = 0; i < 256; i++) begin
        if (y[i]) r = r ^ ({256'b0, x} << i);
      end
    end else begin
      r = {256'b0, x} * {256'b0, y};
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 7) == 0) r = '1;
    return r;
  endfunction

  // Behavioural model: rem = busy cycles still to come; done follows the last one.
  int           rem8 = 0, rem2 = 0;
  logic         ed8, ed2;
  logic [15:0]  ec8, pend8;
  logic [511:0] ec2, pend2, tmp8;

  always @(posedge clk) begin
    if (rst) begin
      rem8 = 0; ed8 = 1'b0; ec8 = '0;
      rem2 = 0; ed2 = 1'b0; ec2 = '0;
    end else begin
      ed8 = (rem8 == 1);
      if (rem8 == 1) ec8 = pend8;
      if (rem8 == 0 && st8) begin
        rem8  = LAT8 - 1;
        tmp8  = ref_mul({248'b0, a8}, {248'b0, b8}, md8);
        pend8 = tmp8[15:0];
      end else if (rem8 > 0) begin
        rem8--;
      end
      ed2 = (rem2 == 1);
      if (rem2 == 1) ec2 = pend2;
      if (rem2 == 0 && st2) begin
        rem2  = LAT2 - 1;
        pend2 = ref_mul(a2, b2, md2);
      end else if (rem2 > 0) begin
        rem2--;
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", busy8, rem8 != 0);
      check("done8", done8, ed8);
      check("c8",    c8,    ec8);
      check("busy2", busy2, rem2 != 0);
      check("done2", done2, ed2);
      check("c2",    c2,    ec2);
    end
  end

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic m, output int lat);
    @(negedge clk);
    a8 = x; b8 = y; md8 = m; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; lat = 1;
    while (done8 !== 1'b1 && lat < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); md8 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op2(input logic [255:0] x, input logic [255:0] y, input logic m, output int lat);
    @(negedge clk);
    a2 = x; b2 = y; md2 = m; st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0; lat = 1;
    while (done2 !== 1'b1 && lat < 80) begin
      a2 = rnd256(); b2 = rnd256();
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog expired at time %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nd, last;
    logic [511:0] e;
    logic [15:0]  ex8;
    rst = 1'b1;
    st8 = 1'b0; md8 = 1'b0; a8 = '0; b8 = '0;
    st2 = 1'b0; md2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_c8", c8, 16'h0);
    check("rst_c2", c2, 512'h0);
    rst = 1'b0;

    // Literal pins on the reference model.
    e = '1; e = e << 257; e = e | 512'd1;
    check("pin_int8",  ref_mul(256'hFF, 256'hFF, 1'b0), 512'hFE01);
    check("pin_cl8",   ref_mul(256'hFF, 256'hFF, 1'b1), 512'h5555);
    check("pin_int256", ref_mul('1, '1, 1'b0), e);

    // Directed WIDTH=8 cases.
    op8(8'hFF, 8'hFF, 1'b0, lat);
    check("lat8", lat, LAT8);
    check("c8_ff_int", c8, 16'hFE01);
    op8(8'hFF, 8'hFF, 1'b1, lat);
    check("c8_ff_cl", c8, 16'h5555);
    op8(8'hFF, 8'hFF, 1'b0, lat);
    check("c8_ff_int2", c8, 16'hFE01);

    // Directed WIDTH=256 cases.
    op2('1, '1, 1'b0, lat);
    check("lat256", lat, LAT2);
    check("c256_ones", c2, e);
    op2('0, rnd256(), 1'b0, lat);
    check("c256_zero", c2, 512'h0);

    // Back-to-back with start held high: accepts in the DONE cycles.
    @(negedge clk);
    st8 = 1'b1; nd = 0; last = 0;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin nd++; last = k; end
      a8 = 8'($urandom); b8 = 8'($urandom); md8 = 1'($urandom);
    end
    st8 = 1'b0;
    check("b2b_count", nd, 4);
    check("b2b_last", last, 28);
    repeat (10) @(negedge clk);

    // Start pulse during MUL is ignored.
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; md8 = 1'b0;
    @(negedge clk); st8 = 1'b0;
    @(negedge clk);
    @(negedge clk); st8 = 1'b1; a8 = 8'h11;
    @(negedge clk); st8 = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) nd++;
    end
    check("midmul_done_count", nd, 1);
    check("midmul_c", c8, 16'h5A * 16'hC3);

    // Reset in the third MUL cycle.
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h9D; b8 = 8'h77; md8 = 1'b1;
    @(negedge clk); st8 = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rstmid_busy", busy8, 1'b0);
    check("rstmid_c", c8, 16'h0);
    check("rstmid_done", done8, 1'b0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) nd++;
    end
    check("rstmid_no_done", nd, 0);
    op8(8'hB7, 8'h2E, 1'b0, lat);
    ex8 = 16'hB7 * 16'h2E;
    check("after_rst_c8", c8, ex8);

    // Randomized traffic on both instances, occasional reset.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      st8 = ($urandom_range(0, 2) == 0);
      a8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      b8 = 8'($urandom); md8 = 1'($urandom);
      st2 = ($urandom_range(0, 3) == 0);
      a2 = rnd256(); b2 = rnd256(); md2 = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; st8 = 1'b0; st2 = 1'b0;
    repeat (40) @(negedge clk);

`ifdef KARATSUBA_OP_COUNT_EN
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("opc_reset", opc8, 32'd0);
    for (int k = 0; k < 3; k++) op8(8'($urandom), 8'($urandom), 1'($urandom), lat);
    @(negedge clk);
    check("opc_three", opc8, 32'd3);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("opc_rst", opc8, 32'd0);
    force dut8.op_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut8.op_count_q;
    check("opc_preload", opc8, 32'hFFFF_FFFF);
    op8(8'h03, 8'h05, 1'b0, lat);
    @(negedge clk);
    check("opc_wrap", opc8, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
